// File: rtl/repack_16to12_if.sv
// Stream interface for the 16-to-12 repacker: input word stream, output word
// stream, flush request/acknowledge and the emitted-word counter.
interface repack_16to12_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             flush_done;
  logic [15:0]      word_cnt;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_last, flush_done, word_cnt
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_last, flush_done, word_cnt
  );
endinterface

// File: rtl/repack_16to12.sv
// Width-reducing repacker: 16-bit words in, dense LSB-first 12-bit words out,
// flush zero-pads the tail. Define REPACK_WORDCNT_EN to enable the word counter.
module repack_16to12 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  repack_16to12_if.slave    bus
);
  localparam int BUF_W = IN_W + OUT_W;
  localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pop_bits, rem_cnt;
  logic             flush_pend_q, flush_pend_d;
  logic             in_ready_w, out_valid_w, push, pop;

  assign in_ready_w  = (cnt_q <= OUT_CNT) && !flush_pend_q;
  assign out_valid_w = (cnt_q >= OUT_CNT) || (flush_pend_q && (cnt_q != '0));
  assign push        = bus.in_valid && in_ready_w;
  assign pop         = out_valid_w && bus.out_ready;

  always_comb begin
    pop_bits = '0;
    if (pop) pop_bits = (cnt_q < OUT_CNT) ? cnt_q : OUT_CNT;
    rem_cnt = cnt_q - pop_bits;
    // bits above cnt are always zero, so a short final word reads zero-padded
    buf_d = pop ? (buf_q >> OUT_W) : buf_q;
    if (push) buf_d = buf_d | (BUF_W'(bus.in_data) << rem_cnt);
    cnt_d = push ? (rem_cnt + IN_CNT) : rem_cnt;
    flush_pend_d = flush_pend_q;
    if (flush_pend_q && (cnt_q == '0)) flush_pend_d = 1'b0;
    else if (bus.flush)                flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_data   = buf_q[OUT_W-1:0];
  assign bus.out_last   = flush_pend_q && (cnt_q != '0) && (cnt_q <= OUT_CNT);
  assign bus.flush_done = flush_pend_q && (cnt_q == '0);

`ifdef REPACK_WORDCNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   word_cnt_q <= '0;
    else if (pop) word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign bus.word_cnt = word_cnt_q;
`else
  assign bus.word_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_repack_16to12.sv
// Scoreboard bench for repack_16to12: a bit-queue reference model predicts the
// 12-bit output stream; a negedge monitor compares every output handshake.
module tb_repack_16to12;
  typedef struct { logic [11:0] d; bit last; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  repack_16to12_if #(.IN_W(16), .OUT_W(12)) bus ();
  repack_16to12 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_seen = 0, done_exp = 0, exp_done_cyc = -1;
  int pops = 0;
  bit model_pend = 0;
  bit rdy_random = 0;
  bit model_bits[$];
  exp_t exp_q[$];
  logic [11:0] got_q[$];
  bit hold_v = 0;
  logic [11:0] hold_d;
  bit hold_l;

  function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endfunction

  function automatic void model_push(input logic [15:0] w);
    logic [11:0] d;
    exp_t e;
    for (int i = 0; i < 16; i++) model_bits.push_back(w[i]);
    while (model_bits.size() >= 12) begin
      for (int i = 0; i < 12; i++) d[i] = model_bits.pop_front();
      e.d = d; e.last = 1'b0;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_flush();
    exp_t e;
    e.d = '0;
    if (model_bits.size() > 0) begin
      for (int i = 0; i < 12; i++) e.d[i] = (model_bits.size() > 0) ? model_bits.pop_front() : 1'b0;
      e.last = 1'b1;
      exp_q.push_back(e);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end else begin
      exp_done_cyc = cyc + 1;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: output side checked first, then accepted inputs fed to the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v) chk(bus.out_valid && bus.out_data == hold_d && bus.out_last == hold_l,
                      "hold_stable", 32'(bus.out_data), 32'(hold_d));
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        pops++;
        if (exp_q.size() == 0) chk(1'b0, "unexpected_out", 32'(bus.out_data), 32'h0);
        else begin
          e = exp_q.pop_front();
          chk(bus.out_data == e.d, "out_data", 32'(bus.out_data), 32'(e.d));
          chk(bus.out_last == e.last, "out_last", 32'(bus.out_last), 32'(e.last));
          if (e.last) exp_done_cyc = cyc + 1;
        end
      end
      if (bus.flush_done) begin
        done_seen++;
        chk(cyc == exp_done_cyc, "flush_done_cycle", 32'(cyc), 32'(exp_done_cyc));
      end
      if (bus.in_valid && bus.in_ready) model_push(bus.in_data);
      if (bus.flush && !model_pend) begin
        model_pend = 1;
        done_exp++;
        model_flush();
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_random) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] w);
    bit acc = 0;
    int n = 0;
    bus.in_data = w;
    bus.in_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk(1'b0, "push_timeout", 32'(n), 32'd500);
  endtask

  task automatic wait_flush_done();
    int n = 0;
    while (done_seen != done_exp && n < 1000) begin tick(); n++; end
    chk(done_seen == done_exp, "flush_done_seen", 32'(done_seen), 32'(done_exp));
    chk(exp_q.size() == 0, "flush_drained", 32'(exp_q.size()), 32'h0);
    model_pend = 0;
  endtask

  task automatic do_flush(input bit twice);
    bus.flush = 1'b1;
    tick();
    if (twice) tick();
    bus.flush = 1'b0;
    wait_flush_done();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
    chk(exp_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic expect_log(input int n, input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d);
    logic [11:0] ref_w[4];
    ref_w[0] = a; ref_w[1] = b; ref_w[2] = c; ref_w[3] = d;
    chk(got_q.size() == n, "log_len", 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk(got_q[i] == ref_w[i], "log_word", 32'(got_q[i]), 32'(ref_w[i]));
    got_q.delete();
  endtask

  function automatic logic [15:0] exp_wc();
`ifdef REPACK_WORDCNT_EN
    return 16'(pops);
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    logic [15:0] w;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.flush = 1'b0;
    repeat (3) tick();
    chk(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    chk(bus.in_ready == 1'b1, "idle_in_ready", 32'(bus.in_ready), 32'h1);
    chk(bus.out_valid == 1'b0, "idle_out_valid", 32'(bus.out_valid), 32'h0);
    chk(bus.out_last == 1'b0, "idle_out_last", 32'(bus.out_last), 32'h0);
    chk(bus.flush_done == 1'b0, "idle_flush_done", 32'(bus.flush_done), 32'h0);
    chk(bus.out_data == 12'h000, "idle_out_data", 32'(bus.out_data), 32'h0);
    chk(bus.word_cnt == 16'h0, "idle_word_cnt", 32'(bus.word_cnt), 32'h0);

    // three words pack exactly into four outputs
    bus.out_ready = 1'b1;
    push(16'h3210); push(16'h7654); push(16'hBA98);
    wait_drain();
    tick();
    expect_log(4, 12'h210, 12'h543, 12'h876, 12'hBA9);
    chk(bus.out_valid == 1'b0, "aligned_empty", 32'(bus.out_valid), 32'h0);

    push(16'hABCD);
    do_flush(0);
    expect_log(2, 12'hBCD, 12'h00A, 12'h0, 12'h0);
    chk(bus.word_cnt == exp_wc(), "word_cnt", 32'(bus.word_cnt), 32'(exp_wc()));

    // backpressure: second word must wait, head word held stable
    bus.out_ready = 1'b0;
    push(16'h1111);
    bus.in_data = 16'h2222; bus.in_valid = 1'b1;
    repeat (3) tick();
    chk(bus.in_ready == 1'b0, "bp_in_ready", 32'(bus.in_ready), 32'h0);
    chk(bus.out_valid == 1'b1, "bp_out_valid", 32'(bus.out_valid), 32'h1);
    chk(bus.out_data == 12'h111, "bp_out_data", 32'(bus.out_data), 32'h111);
    bus.out_ready = 1'b1;
    push(16'h2222);
    wait_drain();
    do_flush(0);
    expect_log(3, 12'h111, 12'h221, 12'h022, 12'h0);

    // empty flush, repeated while still pending
    do_flush(1);
    repeat (5) tick();
    chk(done_seen == done_exp, "double_flush_once", 32'(done_seen), 32'(done_exp));
    expect_log(0, 12'h0, 12'h0, 12'h0, 12'h0);

    // word accepted in the flush cycle is part of the flush
    bus.flush = 1'b1;
    push(16'h5A5A);
    bus.flush = 1'b0;
    wait_flush_done();
    expect_log(2, 12'hA5A, 12'h005, 12'h0, 12'h0);

    rdy_random = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush(0);
      else begin
        w = 16'($urandom);
        push(w);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    do_flush(0);
    rdy_random = 0;
    tick();
    bus.out_ready = 1'b1;
    got_q.delete();
    chk(bus.word_cnt == exp_wc(), "word_cnt_rand", 32'(bus.word_cnt), 32'(exp_wc()));

    // reset while a word is waiting
    bus.out_ready = 1'b0;
    push(16'h1234);
    tick();
    chk(bus.out_valid == 1'b1, "pre_reset_valid", 32'(bus.out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk(bus.out_valid == 1'b0, "reset_drops_valid", 32'(bus.out_valid), 32'h0);
    exp_q.delete(); model_bits.delete(); got_q.delete();
    pops = 0; model_pend = 0; exp_done_cyc = -1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk(bus.in_ready == 1'b1, "post_reset_in_ready", 32'(bus.in_ready), 32'h1);
    chk(bus.word_cnt == 16'h0, "post_reset_word_cnt", 32'(bus.word_cnt), 32'h0);
    bus.out_ready = 1'b1;
    push(16'h0FFF);
    do_flush(0);
    expect_log(2, 12'hFFF, 12'h000, 12'h0, 12'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
